// File: rtl/calc_datapath.sv
// Purpose : operand/opcode capture and ALU stage of the calculator; registers result and flags.
// Latency : result, flags and result_valid update one clk edge after the opcode load (hold=4'b0111).
// Backpressure: none; loads are single-cycle strobes from the sequencer and cannot be stalled.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   estado [1:0]       sequencer state: 0 wait_op1, 1 wait_op2, 2 wait_op, 3 show_result
//   hold [3:0]         sequencer load code, valid for the single transition cycle
//   data_in [W-1:0]    switch bus: operand value, or opcode in bits [1:0]
//   display_value      value for the 7-segment driver (combinational from estado/data_in/result_q)
//   flags [3:0]        {N,Z,C,V} of the registered result
//   result_valid       high while a computed result is held
//   op1_q, op2_q       latched operands
module calc_datapath #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   estado,
   input  logic [3:0]   hold,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] display_value,
   output logic [3:0]   flags,
   output logic         result_valid,
   output logic [W-1:0] op1_q,
   output logic [W-1:0] op2_q
);

   localparam logic [3:0] HOLD_OP1 = 4'b0001;
   localparam logic [3:0] HOLD_OP2 = 4'b0011;
   localparam logic [3:0] HOLD_OPC = 4'b0111;

   localparam logic [1:0] OPC_ADD = 2'b00;
   localparam logic [1:0] OPC_SUB = 2'b01;
   localparam logic [1:0] OPC_AND = 2'b10;

   localparam logic [1:0] ST_WAIT_OP1 = 2'd0;
   localparam logic [1:0] ST_WAIT_OP2 = 2'd1;
   localparam logic [1:0] ST_WAIT_OP  = 2'd2;
   localparam logic [1:0] ST_SHOW     = 2'd3;

   logic [1:0]   opc_q;
   logic [W-1:0] result_q;
   logic [1:0]   estado_q;

   // opc_q is kept for debug visibility only; fold it into a sink so it is not flagged as dead.
   logic         unused_opc;
   assign unused_opc = ^opc_q;

   // ALU works on the live opcode from data_in, not the stale opc_q.
   logic [1:0]   alu_opc;
   logic [W:0]   sum_ext;
   logic [W:0]   diff_ext;
   logic [W-1:0] alu_res;
   logic         alu_c;
   logic         alu_v;
   logic [3:0]   alu_flags;

   assign alu_opc  = data_in[1:0];
   assign sum_ext  = {1'b0, op1_q} + {1'b0, op2_q};
   assign diff_ext = {1'b0, op1_q} - {1'b0, op2_q};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (alu_opc)
         OPC_ADD: begin
            alu_res = sum_ext[W-1:0];
            alu_c   = sum_ext[W];
            // same-sign operands producing a differently-signed result
            alu_v   = (op1_q[W-1] == op2_q[W-1]) && (alu_res[W-1] != op1_q[W-1]);
         end
         OPC_SUB: begin
            alu_res = diff_ext[W-1:0];
            // bit W of the extended difference is the borrow; C means no borrow
            alu_c   = ~diff_ext[W];
            alu_v   = (op1_q[W-1] != op2_q[W-1]) && (alu_res[W-1] != op1_q[W-1]);
         end
         OPC_AND: alu_res = op1_q & op2_q;
         default: alu_res = op1_q | op2_q;
      endcase
      alu_flags = {alu_res[W-1], (alu_res == '0), alu_c, alu_v};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op1_q        <= '0;
         op2_q        <= '0;
         opc_q        <= 2'b00;
         result_q     <= '0;
         flags        <= 4'b0000;
         result_valid <= 1'b0;
         estado_q     <= ST_WAIT_OP1;
      end else begin
         estado_q <= estado;
         case (hold)
            HOLD_OP1: op1_q <= data_in;
            HOLD_OP2: op2_q <= data_in;
            HOLD_OPC: begin
               opc_q        <= alu_opc;
               result_q     <= alu_res;
               flags        <= alu_flags;
               result_valid <= 1'b1;
            end
            default: ;
         endcase
         // Sequencer leaving show_result back to wait_op1 retires the result.
         if (hold != HOLD_OPC && estado_q == ST_SHOW && estado == ST_WAIT_OP1)
            result_valid <= 1'b0;
      end
   end

   always_comb begin
      display_value = data_in;
      case (estado)
         ST_WAIT_OP1, ST_WAIT_OP2: display_value = data_in;
         ST_WAIT_OP:               display_value = {{(W-2){1'b0}}, data_in[1:0]};
         ST_SHOW:                  display_value = result_q;
         default:                  display_value = data_in;
      endcase
   end

endmodule

// File: tb/tb_calc_datapath.sv
// Bench for calc_datapath: drives sequencer-like load sequences and scores the
// show_result outputs against an independent arithmetic model through a queue.
module tb_calc_datapath;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   estado;
   logic [3:0]   hold;
   logic [W-1:0] data_in;
   logic [W-1:0] display_value;
   logic [3:0]   flags;
   logic         result_valid;
   logic [W-1:0] op1_q;
   logic [W-1:0] op2_q;

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   flg;
      string        name;
   } exp_t;

   exp_t sb_q[$];

   int n_cmp = 0;
   int n_err = 0;

   calc_datapath #(.W(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .estado        (estado),
      .hold          (hold),
      .data_in       (data_in),
      .display_value (display_value),
      .flags         (flags),
      .result_valid  (result_valid),
      .op1_q         (op1_q),
      .op2_q         (op2_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model using plain integer arithmetic.
   function automatic exp_t model(input int a, input int b, input int opc, input string name);
      exp_t e;
      int   r, sa, sb, s;
      int   c, v;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      c = 0;
      v = 0;
      case (opc)
         0: begin
            r = (a + b) % 65536;
            c = (a + b >= 65536) ? 1 : 0;
            s = sa + sb;
            v = (s > 32767 || s < -32768) ? 1 : 0;
         end
         1: begin
            r = (a - b + 65536) % 65536;
            c = (a >= b) ? 1 : 0;
            s = sa - sb;
            v = (s > 32767 || s < -32768) ? 1 : 0;
         end
         2: r = a & b;
         default: r = a | b;
      endcase
      e.res  = r[W-1:0];
      e.flg  = {r[15], (r == 0), c[0], v[0]};
      e.name = name;
      return e;
   endfunction

   // Opcode transition: check wait_op display, push expectation, then score in show_result.
   task automatic do_opcode(input int a, input int b, input int opc, input string name);
      exp_t e;
      logic [W-1:0] opc_word;
      estado   = 2'd2;
      hold     = 4'b0111;
      opc_word = 16'hABC0 | opc[W-1:0];
      data_in  = opc_word;
      #1;
      check({name, "_disp_wait_op"}, display_value, opc[31:0] & 32'h3);
      sb_q.push_back(model(a, b, opc, name));
      #3;
      tick();
      estado  = 2'd3;
      hold    = 4'b0000;
      #1;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_sb: scoreboard empty", name);
      end else begin
         e = sb_q.pop_front();
         check({e.name, "_disp"},  display_value, e.res);
         check({e.name, "_flags"}, flags,         e.flg);
         check({e.name, "_valid"}, result_valid,  1);
         // Switch changes while showing the result must not move the display.
         data_in = 16'h5A5A;
         #1;
         check({e.name, "_disp_hold"}, display_value, e.res);
      end
   endtask

   task automatic run_op(input int a, input int b, input int opc, input string name);
      estado  = 2'd0;
      hold    = 4'b0001;
      data_in = a[W-1:0];
      tick();
      estado  = 2'd1;
      hold    = 4'b0011;
      data_in = b[W-1:0];
      tick();
      do_opcode(a, b, opc, name);
      tick();
      estado  = 2'd0;
      hold    = 4'b0000;
      data_in = 16'h0000;
      tick();
      check({name, "_valid_clr"}, result_valid, 0);
   endtask

   initial begin
      logic [W-1:0] snap1, snap2, snap_res;
      logic [3:0]   snap_flg;
      int           ra, rb, ro;

      rst     = 1'b0;
      estado  = 2'd0;
      hold    = 4'b0000;
      data_in = '0;
      #12;
      check("rst_op1",   op1_q,         0);
      check("rst_op2",   op2_q,         0);
      check("rst_flags", flags,         0);
      check("rst_valid", result_valid,  0);
      check("rst_disp",  display_value, 0);
      rst = 1'b1;
      tick();

      // Live preview in wait_op1.
      data_in = 16'h1357;
      #1;
      check("preview_disp", display_value, 16'h1357);

      run_op(16'h0003, 16'h0004, 0, "add");
      run_op(16'h0002, 16'h0005, 1, "sub_borrow");
      run_op(16'h1234, 16'h1234, 1, "sub_equal");
      run_op(16'h7FFF, 16'h0001, 0, "add_ovf");
      run_op(16'hFFFF, 16'h0001, 0, "add_wrap");
      run_op(16'h00F0, 16'h0FF0, 2, "and");
      run_op(16'h00F0, 16'h0FF0, 3, "or");
      run_op(16'h8000, 16'h0001, 1, "sub_ovf");
      for (int i = 0; i < 6; i++) begin
         ra = $urandom_range(0, 65535);
         rb = $urandom_range(0, 65535);
         ro = $urandom_range(0, 3);
         run_op(ra, rb, ro, $sformatf("rand%0d", i));
      end

      // Illegal hold code changes nothing.
      run_op(16'h0011, 16'h0022, 0, "pre_illegal");
      snap1 = op1_q;
      snap2 = op2_q;
      estado  = 2'd3;
      #1;
      snap_res = display_value;
      snap_flg = flags;
      estado  = 2'd0;
      hold    = 4'b1111;
      data_in = 16'hABCD;
      tick();
      hold    = 4'b0000;
      check("illegal_op1",   op1_q, snap1);
      check("illegal_op2",   op2_q, snap2);
      check("illegal_flags", flags, snap_flg);
      check("illegal_valid", result_valid, 0);
      estado = 2'd3;
      #1;
      check("illegal_res", display_value, snap_res);
      estado = 2'd0;
      tick();

      // Mid-sequence reset after op1 load clears immediately, then opcode computes on zeros.
      hold    = 4'b0001;
      data_in = 16'h4444;
      tick();
      hold    = 4'b0000;
      check("midrst_op1_loaded", op1_q, 16'h4444);
      rst = 1'b0;
      #1;
      check("midrst_op1",   op1_q,        0);
      check("midrst_flags", flags,        0);
      check("midrst_valid", result_valid, 0);
      #1;
      rst = 1'b1;
      tick();
      do_opcode(0, 0, 0, "zero_add");
      tick();
      estado = 2'd0;
      tick();
      check("zero_add_valid_clr", result_valid, 0);

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_leftover: got %0d expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
